dmux_sequencer: RTL and testbench

//  Transaction front-end for the fixed-latency pipelined demultiplexer (dmux_lfmr).
//  - Accepts (data, destination) words on a valid/ready handshake.
//  - Drives the demux sel/in and holds both stable for the full pipeline settle time.
//  - Captures the routed word from the demux output bus.
//  - Presents the word on a per-destination registered output with a one-cycle valid strobe.
//  - Serialises traffic so the demux never sees sel/in change mid-propagation.

---
 rtl/dmux_sequencer_if.sv | 28 ++
 rtl/dmux_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dmux_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmux_sequencer_if.sv
// Word-in / routed-word-out bus of the demux sequencer.
// The master side feeds words in and watches the per-destination strobes.
interface dmux_sequencer_if #(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2
);
    localparam int SELW = $clog2(OUTPUT_COUNT) + 1;

    logic                          s_valid;
    logic                          s_ready;
    logic [SELW-1:0]               s_dest;
    logic [WIDTH-1:0]              s_data;
    logic                          abort;
    logic [OUTPUT_COUNT-1:0]       m_valid;
    logic [WIDTH*OUTPUT_COUNT-1:0] m_data;
    logic                          err;
    logic                          busy;

    modport master (
        output s_valid, s_dest, s_data, abort,
        input  s_ready, m_valid, m_data, err, busy
    );

    modport slave (
        input  s_valid, s_dest, s_data, abort,
        output s_ready, m_valid, m_data, err, busy
    );
endinterface

// File: rtl/dmux_sequencer.sv
// Fixed-latency pipelined demultiplexer plus the sequencer that feeds it one word at a
// time, holds sel/in through the pipeline settle time and registers the routed result.
module dmux_lfmr #(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2,
    parameter int LATENCY      = 0,
    parameter int TYPE         = 0,
    localparam int SELW        = $clog2(OUTPUT_COUNT) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SELW-1:0]               sel,
    input  logic [WIDTH-1:0]              in,
    output logic [WIDTH*OUTPUT_COUNT-1:0] out
);
    logic [WIDTH*OUTPUT_COUNT-1:0] route_s;

    generate
        if (TYPE == 0) begin : g_select
            // Route by per-slot select: only the addressed slot carries the word.
            always_comb begin
                route_s = '0;
                for (int k = 0; k < OUTPUT_COUNT; k++) begin
                    if (sel == SELW'(k)) begin
                        route_s[k*WIDTH +: WIDTH] = in;
                    end else begin
                        route_s[k*WIDTH +: WIDTH] = '0;
                    end
                end
            end
        end else begin : g_mask
            // Route by AND-masking the word with each slot's decode bit.
            always_comb begin
                route_s = '0;
                for (int k = 0; k < OUTPUT_COUNT; k++) begin
                    route_s[k*WIDTH +: WIDTH] = in & {WIDTH{sel == SELW'(k)}};
                end
            end
        end

        if (LATENCY == 0) begin : g_comb
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign out      = route_s;
        end else begin : g_pipe
            logic [WIDTH*OUTPUT_COUNT-1:0] pipe_r [LATENCY];

            // Delay line giving the demux its fixed pipeline latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) pipe_r[i] <= '0;
                end else begin
                    pipe_r[0] <= route_s;
                    for (int i = 1; i < LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
                end
            end
            assign out = pipe_r[LATENCY-1];
        end
    endgenerate
endmodule

module dmux_sequencer #(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2,
    parameter int LATENCY      = 0,
    parameter int TYPE         = 0
) (
    input logic             clk,
    input logic             rst_n,
    dmux_sequencer_if.slave bus
);
    localparam int SELW = $clog2(OUTPUT_COUNT) + 1;
    localparam int CNTW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [SELW-1:0] COUNT_SEL = SELW'(OUTPUT_COUNT);
    localparam logic [CNTW-1:0] CNT_LOAD  = CNTW'(LATENCY);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, STROBE = 2'd2} state_t;

    state_t                        state_r, next_s;
    logic [CNTW-1:0]               cnt_r;
    logic [SELW-1:0]               sel_r;
    logic [WIDTH-1:0]              in_r;
    logic                          s_ready_r, busy_r, err_r;
    logic [OUTPUT_COUNT-1:0]       m_valid_r;
    logic [WIDTH*OUTPUT_COUNT-1:0] m_data_r;
    logic [WIDTH*OUTPUT_COUNT-1:0] dmux_out_s;
    logic                          dest_ok_s, load_s, drop_s, capture_s;
    logic [OUTPUT_COUNT-1:0]       strobe_s;
    logic [WIDTH-1:0]              cap_word_s;

    // sel/in come only from registers that change on an accept, so the demux never sees
    // its inputs move while a word is propagating.
    dmux_lfmr #(
        .WIDTH(WIDTH), .OUTPUT_COUNT(OUTPUT_COUNT), .LATENCY(LATENCY), .TYPE(TYPE)
    ) u_dmux (
        .clk(clk), .rst_n(rst_n), .sel(sel_r), .in(in_r), .out(dmux_out_s)
    );

    assign dest_ok_s = (bus.s_dest < COUNT_SEL);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_s;
    end

    // Next-state logic; abort outranks the settle-complete capture.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE, STROBE: begin
                if (bus.s_valid && s_ready_r && dest_ok_s) next_s = SETTLE;
                else                                       next_s = IDLE;
            end
            SETTLE: begin
                if (bus.abort)          next_s = IDLE;
                else if (cnt_r == '0)   next_s = STROBE;
                else                    next_s = SETTLE;
            end
            default: next_s = IDLE;
        endcase
    end

    // Per-state decode of load, drop and capture actions plus the captured slot.
    always_comb begin
        load_s     = 1'b0;
        drop_s     = 1'b0;
        capture_s  = 1'b0;
        strobe_s   = '0;
        cap_word_s = '0;
        case (state_r)
            IDLE, STROBE: begin
                if (bus.s_valid && s_ready_r) begin
                    load_s = dest_ok_s;
                    drop_s = !dest_ok_s;
                end else begin
                    load_s = 1'b0;
                    drop_s = 1'b0;
                end
            end
            SETTLE: begin
                if (!bus.abort && cnt_r == '0) capture_s = 1'b1;
                else                           capture_s = 1'b0;
            end
            default: capture_s = 1'b0;
        endcase
        for (int k = 0; k < OUTPUT_COUNT; k++) begin
            if (sel_r == SELW'(k)) begin
                cap_word_s  = dmux_out_s[k*WIDTH +: WIDTH];
                strobe_s[k] = capture_s;
            end else begin
                strobe_s[k] = 1'b0;
            end
        end
    end

    // Datapath and registered outputs; untouched m_data slots keep their last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            sel_r     <= '0;
            in_r      <= '0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            m_valid_r <= '0;
            m_data_r  <= '0;
        end else begin
            s_ready_r <= (next_s != SETTLE);
            busy_r    <= (next_s == SETTLE);
            err_r     <= drop_s;
            m_valid_r <= strobe_s;
            if (load_s) begin
                sel_r <= bus.s_dest;
                in_r  <= bus.s_data;
                cnt_r <= CNT_LOAD;
            end else if (state_r == SETTLE && cnt_r != '0) begin
                cnt_r <= cnt_r - CNTW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            for (int k = 0; k < OUTPUT_COUNT; k++) begin
                if (strobe_s[k]) m_data_r[k*WIDTH +: WIDTH] <= cap_word_s;
            end
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.busy    = busy_r;
    assign bus.err     = err_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
endmodule

// File: tb/tb_dmux_sequencer.sv
// Bench for dmux_sequencer: three instances (4 dest/latency 2, 3 dest/latency 0,
// 8 dest/latency 0) checked against a cycle-stamped scoreboard and a slot model.
module tb_dmux_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    dmux_sequencer_if #(.WIDTH(8), .OUTPUT_COUNT(4)) if0 ();
    dmux_sequencer_if #(.WIDTH(8), .OUTPUT_COUNT(3)) if1 ();
    dmux_sequencer_if #(.WIDTH(8), .OUTPUT_COUNT(8)) if2 ();

    dmux_sequencer #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2), .TYPE(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    dmux_sequencer #(.WIDTH(8), .OUTPUT_COUNT(3), .LATENCY(0), .TYPE(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    dmux_sequencer #(.WIDTH(8), .OUTPUT_COUNT(8), .LATENCY(0), .TYPE(0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        int         dest;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        int         id;
        int         dest;
        logic [7:0] data;
        bit         bad;
    } vec_t;

    exp_t        sq [3][$];
    int          eq [3][$];
    logic [63:0] model [3];
    int          lat_of [3] = '{2, 0, 0};
    int          cnt_of [3] = '{4, 3, 8};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic rdy_of(input int id);
        case (id)
            0:       return if0.s_ready;
            1:       return if1.s_ready;
            default: return if2.s_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int id);
        case (id)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic err_of(input int id);
        case (id)
            0:       return if0.err;
            1:       return if1.err;
            default: return if2.err;
        endcase
    endfunction

    function automatic logic [63:0] mv_of(input int id);
        case (id)
            0:       return {60'h0, if0.m_valid};
            1:       return {61'h0, if1.m_valid};
            default: return {56'h0, if2.m_valid};
        endcase
    endfunction

    function automatic logic [63:0] md_of(input int id);
        case (id)
            0:       return {32'h0, if0.m_data};
            1:       return {40'h0, if1.m_data};
            default: return if2.m_data;
        endcase
    endfunction

    task automatic drive(input int id, input logic v, input int dest, input logic [7:0] data);
        case (id)
            0: begin if0.s_valid = v; if0.s_dest = 3'(dest); if0.s_data = data; end
            1: begin if1.s_valid = v; if1.s_dest = 3'(dest); if1.s_data = data; end
            default: begin if2.s_valid = v; if2.s_dest = 4'(dest); if2.s_data = data; end
        endcase
    endtask

    // Strobe/err monitor: every strobe must match the oldest expectation in slot, cycle and data.
    task automatic monitor(input int id);
        logic [63:0] mv;
        exp_t        e;
        int          ec;
        mv = mv_of(id);
        if (mv != 64'h0) begin
            if (sq[id].size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL stray_strobe dut%0d: m_valid=0x%0h, required none", id, mv);
            end else begin
                e = sq[id].pop_front();
                chk($sformatf("strobe_slot dut%0d", id), mv, 64'h1 << e.dest);
                chk($sformatf("strobe_cycle dut%0d", id), 64'(cyc), 64'(e.cyc));
                model[id][e.dest*8 +: 8] = e.data;
                chk($sformatf("m_data dut%0d", id), md_of(id), model[id]);
            end
            if (err_of(id)) begin
                n_cmp++; n_bad++;
                $display("FAIL err_with_strobe dut%0d: err=1 m_valid=0x%0h, required exclusive", id, mv);
            end
        end
        if (err_of(id)) begin
            if (eq[id].size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL stray_err dut%0d: err=1, required 0", id);
            end else begin
                ec = eq[id].pop_front();
                chk($sformatf("err_cycle dut%0d", id), 64'(cyc), 64'(ec));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int id = 0; id < 3; id++) monitor(id);
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input int id, input int dest, input logic [7:0] data, input bit bad,
                        output int acc);
        int n;
        n = 0;
        drive(id, 1'b1, dest, data);
        while (!rdy_of(id) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout dut%0d: s_ready=0 for %0d cycles, required 1", id, n);
            drive(id, 1'b0, 0, 8'h00);
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (bad) eq[id].push_back(acc);
        else     sq[id].push_back('{dest, data, acc + lat_of[id] + 1});
        @(negedge clk);
        drive(id, 1'b0, dest, data);
    endtask

    task automatic drain();
        int n;
        exp_t e;
        n = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size() +
                eq[0].size() + eq[1].size() + eq[2].size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int id = 0; id < 3; id++) begin
            while (sq[id].size() != 0) begin
                e = sq[id].pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missing_strobe dut%0d: m_valid stayed 0, required slot %0d data 0x%0h", id, e.dest, e.data);
            end
            while (eq[id].size() != 0) begin
                void'(eq[id].pop_front());
                n_cmp++; n_bad++;
                $display("FAIL missing_err dut%0d: err stayed 0, required err pulse", id);
            end
        end
    endtask

    initial begin
        vec_t tbl [$];
        int   acc, prev, prev_id;
        bit   prev_bad;

        for (int id = 0; id < 3; id++) begin
            drive(id, 1'b0, 0, 8'h00);
            model[id] = 64'h0;
        end
        if0.abort = 1'b0; if1.abort = 1'b0; if2.abort = 1'b0;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("rst_s_ready dut%0d", id), 64'(rdy_of(id)), 64'h0);
            chk($sformatf("rst_m_valid dut%0d", id), mv_of(id), 64'h0);
            chk($sformatf("rst_m_data dut%0d", id), md_of(id), 64'h0);
            chk($sformatf("rst_err dut%0d", id), 64'(err_of(id)), 64'h0);
            chk($sformatf("rst_busy dut%0d", id), 64'(busy_of(id)), 64'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int id = 0; id < 3; id++)
            chk($sformatf("ready_after_rst dut%0d", id), 64'(rdy_of(id)), 64'h1);

        // Single route: dest 2, 0xA5 on the latency-2 instance.
        send(0, 2, 8'hA5, 1'b0, acc);
        chk("busy_in_settle", 64'(busy_of(0)), 64'h1);
        chk("ready_in_settle", 64'(rdy_of(0)), 64'h0);
        drain();

        // Table of vectors; consecutive entries on one instance run back-to-back.
        tbl.push_back('{0, 0, 8'h11, 1'b0});
        tbl.push_back('{0, 1, 8'h22, 1'b0});
        tbl.push_back('{0, 3, 8'h33, 1'b0});
        tbl.push_back('{0, 5, 8'hEE, 1'b1});
        tbl.push_back('{0, 2, 8'h44, 1'b0});
        tbl.push_back('{1, 3, 8'hC3, 1'b1});
        tbl.push_back('{1, 0, 8'h5C, 1'b0});
        tbl.push_back('{1, 7, 8'h99, 1'b1});
        tbl.push_back('{1, 2, 8'h81, 1'b0});
        tbl.push_back('{2, 7, 8'h7E, 1'b0});
        tbl.push_back('{2, 9, 8'h01, 1'b1});
        tbl.push_back('{2, 0, 8'hF0, 1'b0});
        prev = -1; prev_id = -1; prev_bad = 1'b0;
        foreach (tbl[i]) begin
            send(tbl[i].id, tbl[i].dest, tbl[i].data, tbl[i].bad, acc);
            if (tbl[i].bad)
                chk($sformatf("ready_after_bad v%0d", i), 64'(rdy_of(tbl[i].id)), 64'h1);
            if (prev_id == tbl[i].id && prev >= 0)
                chk($sformatf("accept_spacing v%0d", i), 64'(acc - prev),
                    64'(prev_bad ? 1 : lat_of[tbl[i].id] + 2));
            prev = acc; prev_id = tbl[i].id; prev_bad = tbl[i].bad;
        end
        drain();

        // Abort on the last settle cycle: no strobe, slot 1 keeps 0x22.
        send(0, 1, 8'h5A, 1'b0, acc);
        void'(sq[0].pop_back());
        repeat (2) @(negedge clk);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        chk("ready_after_abort", 64'(rdy_of(0)), 64'h1);
        chk("busy_after_abort", 64'(busy_of(0)), 64'h0);
        repeat (4) @(negedge clk);
        chk("m_data_after_abort", md_of(0), model[0]);

        // Latency-0 sweep over every destination with random data.
        for (int id = 1; id < 3; id++) begin
            prev = -1;
            for (int r = 0; r < 2; r++) begin
                for (int d = 0; d < cnt_of[id]; d++) begin
                    send(id, d, 8'($urandom_range(255)), 1'b0, acc);
                    if (prev >= 0)
                        chk($sformatf("sweep_spacing dut%0d", id), 64'(acc - prev), 64'h2);
                    prev = acc;
                end
            end
            drain();
        end

        // Reset in the middle of SETTLE: transaction lost, nothing strobes afterwards.
        send(0, 2, 8'h77, 1'b0, acc);
        void'(sq[0].pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        for (int id = 0; id < 3; id++) model[id] = 64'h0;
        #1;
        chk("midrst_m_valid", mv_of(0), 64'h0);
        chk("midrst_m_data", md_of(0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(rdy_of(0)), 64'h1);
        repeat (6) @(negedge clk);
        send(0, 3, 8'h3C, 1'b0, acc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
